// File: rtl/ex_alu_stage_if.sv
// Handshake and data bundle between operand fetch, the execute stage and the memory stage.
// The slave modport is the execute stage; the master modport is the surrounding pipeline.
interface ex_alu_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  control;
    logic        setflags;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic [4:0]  out_tag;
    logic        out_illegal;

    modport master (
        output in_valid, control, setflags, a, b, shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, control, setflags, a, b, shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_tag, out_illegal
    );
endinterface

// File: rtl/ex_alu_stage.sv
// Registered 64-bit execute stage with NZCV flag register and a one-bit-per-cycle shifter.
// Non-shift ops and zero-distance shifts complete on the accept edge; longer shifts occupy SHIFT.
module ex_alu_stage (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ex_alu_stage_if.slave bus,
    output logic [3:0]    flags,
    output logic          busy
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PSB = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_LSR = 4'b1010;
    localparam logic [3:0] OP_LSL = 4'b1011;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic [5:0]  cnt_r;
    logic [63:0] sh_r, shift_next_s;
    logic        sh_left_r, sf_r;
    logic [4:0]  tag_r;
    logic        out_valid_r, out_zero_r, out_illegal_r;
    logic [63:0] out_result_r;
    logic [4:0]  out_tag_r;
    logic [3:0]  flags_r;

    logic [64:0] sum_s;
    logic [63:0] alu_res_s, load_res_s;
    logic        alu_c_s, alu_v_s, legal_s, shift_op_s, long_shift_s;
    logic        in_ready_s, accept_s, shift_done_s;
    logic        load_s, load_c_s, load_v_s, load_ill_s, load_sf_s;
    logic [4:0]  load_tag_s;

    assign in_ready_s   = !rst && !flush && (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
    assign accept_s     = bus.in_valid && in_ready_s;
    assign long_shift_s = shift_op_s && (bus.shamt != 6'd0);
    assign shift_done_s = (state_r == ST_SHIFT) && (cnt_r == 6'd1);
    assign shift_next_s = sh_left_r ? {sh_r[62:0], 1'b0} : {1'b0, sh_r[63:1]};

    // Single-cycle ALU result and arithmetic flags for the op presented upstream
    always_comb begin
        sum_s      = 65'd0;
        alu_res_s  = 64'd0;
        alu_c_s    = 1'b0;
        alu_v_s    = 1'b0;
        legal_s    = 1'b1;
        shift_op_s = 1'b0;
        case (bus.control)
            OP_AND: alu_res_s = bus.a & bus.b;
            OP_ORR: alu_res_s = bus.a | bus.b;
            OP_EOR: alu_res_s = bus.a ^ bus.b;
            OP_PSB: alu_res_s = bus.b;
            OP_ADD: begin
                sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
                alu_res_s = sum_s[63:0];
                alu_c_s   = sum_s[64];
                alu_v_s   = (bus.a[63] == bus.b[63]) && (sum_s[63] != bus.a[63]);
            end
            OP_SUB: begin
                sum_s     = {1'b0, bus.a} + {1'b0, ~bus.b} + 65'd1;
                alu_res_s = sum_s[63:0];
                alu_c_s   = sum_s[64];
                alu_v_s   = (bus.a[63] != bus.b[63]) && (sum_s[63] != bus.a[63]);
            end
            OP_LSR, OP_LSL: begin
                // only reaches the output directly when shamt is zero
                shift_op_s = 1'b1;
                alu_res_s  = bus.a;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Select what, if anything, lands in the output register this edge
    always_comb begin
        load_s     = 1'b0;
        load_res_s = 64'd0;
        load_c_s   = 1'b0;
        load_v_s   = 1'b0;
        load_ill_s = 1'b0;
        load_sf_s  = 1'b0;
        load_tag_s = 5'd0;
        if (shift_done_s && !flush) begin
            load_s     = 1'b1;
            load_res_s = shift_next_s;
            load_sf_s  = sf_r;
            load_tag_s = tag_r;
        end else if (accept_s && !long_shift_s) begin
            load_s     = 1'b1;
            load_res_s = legal_s ? alu_res_s : 64'd0;
            load_c_s   = alu_c_s;
            load_v_s   = alu_v_s;
            load_ill_s = !legal_s;
            load_sf_s  = bus.setflags && legal_s;
            load_tag_s = bus.in_tag;
        end else begin
            load_s = 1'b0;
        end
    end

    // Next-state logic; flush aborts any shift in progress
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = (accept_s && long_shift_s) ? ST_SHIFT : ST_IDLE;
                ST_SHIFT: state_nxt_s = (cnt_r == 6'd1) ? ST_IDLE : ST_SHIFT;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Iterative shifter: operand, remaining count and the attributes latched at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r      <= 64'd0;
            cnt_r     <= 6'd0;
            sh_left_r <= 1'b0;
            sf_r      <= 1'b0;
            tag_r     <= 5'd0;
        end else if (flush) begin
            cnt_r <= 6'd0;
        end else if (accept_s && long_shift_s) begin
            sh_r      <= bus.a;
            cnt_r     <= bus.shamt;
            sh_left_r <= (bus.control == OP_LSL);
            sf_r      <= bus.setflags;
            tag_r     <= bus.in_tag;
        end else if (state_r == ST_SHIFT) begin
            sh_r  <= shift_next_s;
            cnt_r <= cnt_r - 6'd1;
        end
    end

    // Output register and NZCV; flags move only when a legal op completes with setflags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= 64'd0;
            out_zero_r    <= 1'b0;
            out_tag_r     <= 5'd0;
            out_illegal_r <= 1'b0;
            flags_r       <= 4'b0000;
        end else if (flush) begin
            out_valid_r   <= 1'b0;
            out_illegal_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= load_res_s;
            out_zero_r    <= (load_res_s == 64'd0);
            out_tag_r     <= load_tag_s;
            out_illegal_r <= load_ill_s;
            if (load_sf_s) begin
                flags_r <= {load_res_s[63], (load_res_s == 64'd0), load_c_s, load_v_s};
            end
        end else if (bus.out_ready && out_valid_r) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_zero    = out_zero_r;
    assign bus.out_tag     = out_tag_r;
    assign bus.out_illegal = out_illegal_r;
    assign flags           = flags_r;
    assign busy            = (state_r == ST_SHIFT);
endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: directed test-plan cases followed by randomized ops
// checked against an arithmetic reference model.
module tb_ex_alu_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] flags;
    logic       busy;

    ex_alu_stage_if bus();

    ex_alu_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .flags (flags),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        ill;
        logic [3:0]  fl;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [3:0] mflags = 4'b0000;
    bit         rand_ready = 1'b0;
    bit         presented = 1'b0;
    logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour straight from the operation table
    function automatic void model(input logic [3:0] c, input logic sf, input logic [63:0] a,
                                  input logic [63:0] b, input logic [5:0] sh,
                                  input logic [3:0] fl_i, output logic [3:0] fl_o,
                                  output logic [63:0] r, output logic ill);
        logic cf, vf;
        cf = 1'b0; vf = 1'b0; ill = 1'b0; r = 64'd0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin r = a + b; cf = (r < a); vf = (a[63] == b[63]) && (r[63] != a[63]); end
            4'h6: begin r = a - b; cf = (a >= b); vf = (a[63] != b[63]) && (r[63] != a[63]); end
            4'h7: r = b;
            4'h8: r = a ^ b;
            4'hA: r = a >> sh;
            4'hB: r = a << sh;
            default: ill = 1'b1;
        endcase
        fl_o = (sf && !ill) ? {r[63], (r == 64'd0), cf, vf} : fl_i;
    endfunction

    task automatic issue(input logic [3:0] c, input logic sf, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] sh, input logic [4:0] tag,
                         input bit track);
        exp_t e;
        logic [63:0] r;
        logic ill;
        logic [3:0] fo;
        bit ok;
        bus.in_valid = 1'b1; bus.control = c; bus.setflags = sf;
        bus.a = a; bus.b = b; bus.shamt = sh; bus.in_tag = tag;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready actual 0 required 1");
        end else if (track) begin
            model(c, sf, a, b, sh, mflags, fo, r, ill);
            mflags = fo;
            e.res = r; e.tag = tag; e.ill = ill; e.fl = fo; e.acc = cyc + 1;
            e.lat = ((c == 4'hA || c == 4'hB) && sh != 6'd0) ? int'(sh) : 0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1; flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_in_reset", bus.in_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_result", bus.out_result, 64'd0);
        chk("rst_out_zero", bus.out_zero, 1'b0);
        chk("rst_out_tag", bus.out_tag, 5'd0);
        chk("rst_out_illegal", bus.out_illegal, 1'b0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        sb.delete(); mflags = 4'b0000; presented = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 3000 && (sb.size() != 0 || bus.out_valid); i++) @(negedge clk);
        chk("drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard whenever the stage hands off a result
    initial forever begin
        @(negedge clk);
        if (rst) begin
            presented = 1'b0;
        end else begin
            if (busy) chk("in_ready_while_busy", bus.in_ready, 1'b0);
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_output: out_valid actual 1 required 0");
                end else begin
                    if (!presented) begin
                        chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                        presented = 1'b1;
                    end
                    if (bus.out_ready) begin
                        chk("result", bus.out_result, sb[0].res);
                        chk("zero", bus.out_zero, (sb[0].res == 64'd0));
                        chk("tag", bus.out_tag, sb[0].tag);
                        chk("illegal", bus.out_illegal, sb[0].ill);
                        chk("flags", flags, sb[0].fl);
                        void'(sb.pop_front());
                        presented = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d results pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, ra, rb;
        logic [3:0]  fo, c;
        logic        ill;
        logic [5:0]  sh;
        int          n_ok, c0;
        bus.in_valid = 1'b0; bus.control = 4'h0; bus.setflags = 1'b0;
        bus.a = 64'd0; bus.b = 64'd0; bus.shamt = 6'd0; bus.in_tag = 5'd0;
        bus.out_ready = 1'b1; flush = 1'b0; rst = 1'b1;
        do_reset();

        issue(4'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 5'd1, 1'b1);
        @(negedge clk); chk("tp_add_flags", flags, 4'b0110);
        @(posedge clk); #1;
        issue(4'h6, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 6'd0, 5'd2, 1'b1);
        @(negedge clk); chk("tp_sub_flags", flags, 4'b0011);
        @(posedge clk); #1;
        issue(4'h6, 1'b0, 64'd5, 64'd9, 6'd0, 5'd3, 1'b1);
        @(negedge clk); chk("tp_sub_noflags", flags, 4'b0011);
        @(posedge clk); #1;
        issue(4'hF, 1'b1, 64'd7, 64'd7, 6'd0, 5'd4, 1'b1);
        @(negedge clk);
        chk("tp_illegal_flag", bus.out_illegal, 1'b1);
        chk("tp_illegal_flags", flags, 4'b0011);
        @(posedge clk); #1;

        // LSL by 63: busy for 63 cycles, then result
        issue(4'hB, 1'b1, 64'd1, 64'd0, 6'd63, 5'd5, 1'b1);
        n_ok = 0;
        repeat (63) begin
            @(negedge clk);
            if (busy && !bus.in_ready && !bus.out_valid) n_ok++;
        end
        chk("lsl63_busy_cycles", 64'(n_ok), 64'd63);
        @(posedge clk); #1;
        issue(4'hB, 1'b0, 64'h1234, 64'd0, 6'd0, 5'd6, 1'b1);

        // back-to-back logic ops with the sink always ready
        @(posedge clk); #1;
        c0 = cyc;
        issue(4'h0, 1'b1, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 6'd0, 5'd7, 1'b1);
        issue(4'h1, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 6'd0, 5'd8, 1'b1);
        issue(4'h8, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 5'd9, 1'b1);
        issue(4'h7, 1'b1, 64'hDEAD, 64'd0, 6'd0, 5'd10, 1'b1);
        chk("b2b_cycles", 64'(cyc - c0), 64'd4);

        // stall: result must hold while out_ready is low
        wait_drain();
        bus.out_ready = 1'b0;
        ra = 64'hFF00_FF00_1111_2222; rb = 64'h0FF0_0FF0_3333_1111;
        model(4'h0, 1'b0, ra, rb, 6'd0, mflags, fo, r, ill);
        issue(4'h0, 1'b0, ra, rb, 6'd0, 5'd11, 1'b1);
        bus.in_valid = 1'b1; bus.control = 4'h1;
        n_ok = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_result === r && !bus.in_ready) n_ok++;
        end
        chk("stall_hold", 64'(n_ok), 64'd3);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(4'h1, 1'b1, 64'd0, 64'd0, 6'd0, 5'd12, 1'b1);

        // flush in the fifth cycle of an LSR by 20
        wait_drain();
        issue(4'hA, 1'b1, 64'hFFFF_0000_0000_0000, 64'd0, 6'd20, 5'd13, 1'b0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk); chk("in_ready_during_flush", bus.in_ready, 1'b0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_flags", flags, mflags);
        @(posedge clk); #1;
        issue(4'h2, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 5'd14, 1'b1);

        // reset in the middle of a shift
        wait_drain();
        issue(4'hB, 1'b1, 64'h3, 64'd0, 6'd30, 5'd15, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        issue(4'h2, 1'b1, 64'd40, 64'd2, 6'd0, 5'd16, 1'b1);

        // randomized traffic with a stuttering sink
        rand_ready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            c  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
            sh = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
            ra = ($urandom_range(0, 4) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            rb = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
            issue(c, 1'($urandom), ra, rb, sh, 5'($urandom), 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
